// File: rtl/stackcpu_run_ctrl_pkg.sv
// Shared definitions for the stackCPU run controller: default widths, job status and controller states.
package stackCPU_DEFS;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF    = 8;
  localparam int MAX_CYCLES_DEF  = 1024;

  typedef enum logic [2:0] {
    RS_OK      = 3'd0,
    RS_HALT    = 3'd1,
    RS_ERROR   = 3'd2,
    RS_TIMEOUT = 3'd3,
    RS_ABORT   = 3'd4
  } run_status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/stackcpu_run_ctrl_watchdog.sv
// Loadable up-counter with clear and enable; expired_o flags count >= limit_i and stops counting there.
module run_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q >= limit_i);

  // Clear wins over load, load wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stackcpu_run_ctrl.sv
// Sequences one stackCPU job: reset hold, run with pc-to-memory translation, terminal detection and report.
module stackcpu_run_ctrl
  import stackCPU_DEFS::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int MAX_CYCLES  = MAX_CYCLES_DEF,
  parameter int RST_CYCLES  = 2,
  localparam int CW         = $clog2(MAX_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PC_WIDTH-1:0]    base_addr,
  input  logic [PC_WIDTH-1:0]    length,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [DATA_WIDTH-1:0]  result_out,
  output logic [CW-1:0]          cycles_out,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   cpu_reset,
  output logic [INSTR_WIDTH-1:0] cpu_instruction,
  input  logic [PC_WIDTH-1:0]    cpu_pc,
  input  logic [DATA_WIDTH-1:0]  cpu_result,
  input  logic                   cpu_error,
  input  logic                   cpu_halt
);

  localparam logic [CW-1:0] RST_LIMIT = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LIMIT = CW'(MAX_CYCLES - 1);

  run_state_t                state_q, state_d;
  run_status_t               status_q, status_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [CW-1:0]             cycles_q, cycles_d;
  logic [PC_WIDTH-1:0]       base_q, base_d;
  logic [PC_WIDTH-1:0]       len_q, len_d;

  logic                      wd_clr, wd_load, wd_en, wd_expired;
  logic [CW-1:0]             wd_limit, wd_cnt;
  logic                      term;
  run_status_t               term_status;

  // One counter serves both phases: it holds completed cycles of the current phase.
  run_watchdog #(.W(CW)) u_watchdog (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (wd_clr),
    .load_i     (wd_load),
    .load_val_i ('0),
    .en_i       (wd_en),
    .limit_i    (wd_limit),
    .cnt_o      (wd_cnt),
    .expired_o  (wd_expired)
  );

  assign busy            = (state_q == S_RST) || (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign cpu_reset       = (state_q != S_RUN);
  assign status          = status_q;
  assign result_out      = result_q;
  assign cycles_out      = cycles_q;
  assign cpu_instruction = mem_rdata;
  assign mem_addr        = (state_q == S_RUN) ? (base_q + cpu_pc) : '0;

  always_comb begin
    term        = 1'b1;
    term_status = RS_OK;
    if (abort) begin
      term_status = RS_ABORT;
    end else if (cpu_error) begin
      term_status = RS_ERROR;
    end else if (cpu_halt) begin
      term_status = RS_HALT;
    end else if (cpu_pc >= len_q) begin
      term_status = RS_OK;
    end else if (wd_expired) begin
      term_status = RS_TIMEOUT;
    end else begin
      term = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    result_d = result_q;
    cycles_d = cycles_q;
    base_d   = base_q;
    len_d    = len_q;
    wd_clr   = 1'b0;
    wd_load  = 1'b0;
    wd_en    = 1'b0;
    wd_limit = RST_LIMIT;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RST;
          base_d   = base_addr;
          len_d    = length;
          cycles_d = '0;
          wd_clr   = 1'b1;
        end
      end
      S_RST: begin
        wd_en = 1'b1;
        if (abort) begin
          state_d  = S_DONE;
          status_d = RS_ABORT;
          result_d = cpu_result;
        end else if (wd_expired) begin
          state_d = S_RUN;
          wd_load = 1'b1;
        end
      end
      S_RUN: begin
        wd_en    = 1'b1;
        wd_limit = RUN_LIMIT;
        if (term) begin
          state_d  = S_DONE;
          status_d = term_status;
          result_d = cpu_result;
          cycles_d = wd_cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      status_q <= RS_OK;
      result_q <= '0;
      cycles_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      base_q   <= base_d;
      len_q    <= len_d;
    end
  end

endmodule

// File: tb/tb_stackcpu_run_ctrl.sv
// Bench for stackcpu_run_ctrl: behavioural stack CPU and program memory around the DUT, job-level reference model.
module tb_stackcpu_run_ctrl;

  localparam int RSTC = 2;
  localparam int MAXC = 16;
  localparam int CW   = $clog2(MAXC) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [7:0]    base_addr, length;
  logic          busy, done;
  logic [2:0]    status;
  logic [15:0]   result_out;
  logic [CW-1:0] cycles_out;
  logic [7:0]    mem_addr;
  logic [15:0]   mem_rdata;
  logic          cpu_reset;
  logic [15:0]   cpu_instruction;
  logic [7:0]    cpu_pc;
  logic [15:0]   cpu_result;
  logic          cpu_error, cpu_halt;

  stackcpu_run_ctrl #(
    .DATA_WIDTH(16), .INSTR_WIDTH(16), .PC_WIDTH(8), .MAX_CYCLES(MAXC), .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .status(status), .result_out(result_out), .cycles_out(cycles_out),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .cpu_reset(cpu_reset),
    .cpu_instruction(cpu_instruction), .cpu_pc(cpu_pc), .cpu_result(cpu_result),
    .cpu_error(cpu_error), .cpu_halt(cpu_halt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // program memory and behavioural CPU: op[15:12] 1=PUSH imm12, 2=ADD, else NOP
  logic [15:0] pmem [256];
  assign mem_rdata = pmem[mem_addr];

  int          stall_g = 0, err_at_g = 0, halt_at_g = 0;
  int          run_k = 0, sp = 0;
  logic [7:0]  m_pc = '0;
  logic [15:0] m_res = '0;
  logic [15:0] stk [16];

  always @(posedge clk) begin
    if (cpu_reset) begin
      m_pc <= '0; sp <= 0; m_res <= '0; run_k <= 0;
    end else begin
      run_k <= run_k + 1;
      if (stall_g == 0) begin
        m_pc <= m_pc + 8'd1;
        case (cpu_instruction[15:12])
          4'd1: begin
            stk[sp] <= {4'd0, cpu_instruction[11:0]};
            sp      <= sp + 1;
            m_res   <= {4'd0, cpu_instruction[11:0]};
          end
          4'd2: begin
            stk[sp-2] <= stk[sp-2] + stk[sp-1];
            sp        <= sp - 1;
            m_res     <= stk[sp-2] + stk[sp-1];
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_pc     = m_pc;
  assign cpu_result = m_res;
  assign cpu_error  = !cpu_reset && (err_at_g != 0) && (run_k + 1 == err_at_g);
  assign cpu_halt   = !cpu_reset && (halt_at_g != 0) && (run_k + 1 == halt_at_g);

  // scoreboard
  int         total = 0, bad = 0;
  int         prog_q[$];
  logic [7:0] exp_q[$];
  int         exp_status, exp_cyc, exp_n, exp_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // top of stack after executing the first n instructions of prog_q (beyond it: NOPs)
  function automatic int top_after(input int n);
    int st[$];
    int a, b, op;
    for (int p = 0; p < n; p++) begin
      if (p < prog_q.size()) begin
        op = prog_q[p] >> 12;
        if (op == 1) st.push_back(prog_q[p] & 32'hfff);
        else if (op == 2) begin
          a = st.pop_back(); b = st.pop_back();
          st.push_back((a + b) & 32'hffff);
        end
      end
    end
    return (st.size() > 0) ? st[$] : 0;
  endfunction

  // job-level reference: walk RUN cycles, first terminal rule in priority order wins
  function automatic void model(input int base, input int len, input int stall,
                                input int err_at, input int halt_at, input int abort_at,
                                input int abort_rst);
    int pc, st;
    exp_q.delete();
    if (abort_rst != 0) begin
      exp_status = 4; exp_cyc = 0; exp_n = abort_rst + 1; exp_res = 0;
      return;
    end
    for (int k = 1; k <= MAXC; k++) begin
      pc = (stall != 0) ? 0 : k - 1;
      st = -1;
      exp_q.push_back(8'((base + pc) % 256));
      if (abort_at == k) st = 4;
      else if (err_at == k) st = 2;
      else if (halt_at == k) st = 1;
      else if (pc >= len) st = 0;
      else if (k == MAXC) st = 3;
      if (st >= 0) begin
        exp_status = st; exp_cyc = k; exp_n = RSTC + k + 1;
        exp_res = (stall != 0) ? 0 : top_after(k - 1);
        return;
      end
    end
  endfunction

  // driver: one complete job from start to the idle cycle after done
  task automatic run_job(input string tag, input int base, input int len, input int stall,
                         input int err_at, input int halt_at, input int abort_at,
                         input int abort_rst);
    int n, done_n;
    logic [7:0] obs_q[$];
    for (int i = 0; i < 256; i++) pmem[i] = 16'h0;
    for (int i = 0; i < prog_q.size(); i++) pmem[(base + i) % 256] = 16'(prog_q[i]);
    stall_g = stall; err_at_g = err_at; halt_at_g = halt_at;
    model(base, len, stall, err_at, halt_at, abort_at, abort_rst);
    @(negedge clk);
    start = 1'b1; base_addr = 8'(base); length = 8'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_after_start"}, busy, 1);
    n = 0; done_n = 0;
    while (done_n == 0 && n < 40) begin
      @(negedge clk); n++;
      abort = (abort_rst != 0 && n == abort_rst) || (abort_at != 0 && n == RSTC + abort_at);
      if (!cpu_reset) begin
        obs_q.push_back(mem_addr);
        if (obs_q.size() == 1) chk({tag, ".instr"}, cpu_instruction, pmem[(base) % 256]);
      end
      if (done) done_n = n;
    end
    abort = 1'b0;
    chk({tag, ".done_cycle"}, done_n, exp_n);
    chk({tag, ".status"}, status, exp_status);
    if (abort_rst == 0) chk({tag, ".result"}, result_out, exp_res);
    chk({tag, ".cycles"}, cycles_out, exp_cyc);
    chk({tag, ".cpu_reset_done"}, cpu_reset, 1);
    chk({tag, ".busy_done"}, busy, 0);
    chk({tag, ".addr_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.addr%0d", tag, i), obs_q[i], exp_q[i]);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
  endtask

  initial begin
    int s, d, len, n, base;
    reset = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < 256; i++) pmem[i] = 16'h0;
    pmem[0] = 16'h1234;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.status", status, 0);
    chk("rst.result", result_out, 0);
    chk("rst.cycles", cycles_out, 0);
    chk("rst.cpu_reset", cpu_reset, 1);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.instr", cpu_instruction, 16'h1234);
    reset = 1'b1;
    @(negedge clk);

    prog_q = '{32'h1005, 32'h1003, 32'h2000};
    run_job("add", 8, 3, 0, 0, 0, 0, 0);
    prog_q = '{32'h1007, 32'h1009};
    run_job("wrap", 255, 2, 0, 0, 0, 0, 0);
    prog_q = '{32'h1001, 32'h1002, 32'h1003, 32'h1004};
    run_job("err_halt", 20, 10, 0, 2, 2, 0, 0);
    run_job("halt", 30, 10, 0, 0, 3, 0, 0);
    prog_q.delete();
    run_job("timeout", 0, 100, 1, 0, 0, 0, 0);
    run_job("abort_rst2", 0, 10, 0, 0, 0, 0, 2);
    prog_q = '{32'h1001, 32'h1002, 32'h2000, 32'h1004, 32'h2000};
    run_job("abort_run4", 40, 10, 0, 0, 0, 4, 0);
    run_job("len0", 40, 0, 0, 0, 0, 0, 0);

    // start held through DONE is only accepted once back in IDLE
    @(negedge clk);
    start = 1'b1; base_addr = 8'd0; length = 8'd0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("hold.done_seen", done, 1);
    chk("hold.status", status, 0);
    chk("hold.cycles", cycles_out, 1);
    start = 1'b1;
    @(negedge clk);
    chk("hold.ignored_in_done", busy, 0);
    chk("hold.no_done", done, 0);
    @(negedge clk);
    chk("hold.accepted_in_idle", busy, 1);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("hold.abort_done", done, 1);
    chk("hold.abort_status", status, 4);
    chk("hold.abort_cycles", cycles_out, 0);
    @(negedge clk);

    // reset dropped mid-RUN discards the job
    prog_q.delete();
    for (int i = 0; i < 256; i++) pmem[i] = 16'h0;
    stall_g = 1; err_at_g = 0; halt_at_g = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 8'd7; length = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.in_run", cpu_reset, 0);
    chk("midrst.mem_addr_run", mem_addr, 7);
    reset = 1'b0; #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.cpu_reset", cpu_reset, 1);
    chk("midrst.done", done, 0);
    chk("midrst.mem_addr", mem_addr, 0);
    @(negedge clk);
    chk("midrst.no_done", done, 0);
    reset = 1'b1;
    prog_q = '{32'h1005, 32'h1003, 32'h2000};
    run_job("after_rst", 8, 3, 0, 0, 0, 0, 0);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      prog_q.delete();
      s = $urandom_range(1, 8);
      d = 0;
      for (int i = 0; i < s; i++) begin
        if (d >= 2 && $urandom_range(0, 1) == 1) begin prog_q.push_back(32'h2000); d--; end
        else begin prog_q.push_back(32'h1000 | $urandom_range(0, 4095)); d++; end
      end
      base = $urandom_range(0, 255);
      len  = $urandom_range(0, s + 2);
      run_job($sformatf("rnd%0d", j), base, len,
              ($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0,
              ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
